// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit for the execute stage.
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring division) one
// bit per cycle, owns the HI/LO registers and serves MTHI/MTLO writes.
// Any accepted operation takes 34 cycles from start to the done pulse.
module md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               prod_neg;
    logic               quo_neg;
    logic               rem_neg;
    logic               div_zero;
    logic [WIDTH-1:0]   dvd_orig;   // original dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]   mcand_dvs;  // |A| for multiply, |B| (divisor) for divide
    logic [WIDTH-1:0]   shreg;      // |B| shifting right for multiply, |A| shifting left for divide
    logic [2*WIDTH-1:0] acc;        // product, or {remainder, quotient}

    logic               op_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_neg;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               fin_commit;

    assign busy       = (state != S_IDLE);
    assign op_signed  = ~md_op[0];
    assign abs_a      = (op_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign abs_b      = (op_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    assign fin_commit = (state == S_FIN) && !flush;

    // One radix-2 iteration: shift-add for multiply, restoring step for divide.
    // NOTE: combinational blocks use blocking assignments and assign every
    // output first, so no latch can be inferred.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (shreg[0] ? {1'b0, mcand_dvs} : '0);
        // The partial remainder is below the divisor, so after shifting it is
        // below twice the divisor and a 33-bit difference carries the sign in
        // its top bit.
        div_shift = {acc[2*WIDTH-1:WIDTH], shreg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_dvs};
        div_neg   = div_diff[WIDTH];
        step_next = acc;
        if (is_div)
            step_next = {(div_neg ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                         acc[WIDTH-2:0], ~div_neg};
        else
            step_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Sign correction and divide-by-zero override applied while in FIN.
    always_comb begin
        prod_fix = prod_neg ? (~acc + 1'b1) : acc;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = dvd_orig;
                res_lo = '1;
            end else begin
                res_hi = rem_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
                res_lo = quo_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
            end
        end
    end

    // Control FSM, operand latching and iteration datapath.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            prod_neg  <= 1'b0;
            quo_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            div_zero  <= 1'b0;
            dvd_orig  <= '0;
            mcand_dvs <= '0;
            shreg     <= '0;
            acc       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        state    <= S_CALC;
                        cnt      <= '0;
                        acc      <= '0;
                        is_div   <= md_op[1];
                        prod_neg <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                        quo_neg  <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                        rem_neg  <= op_signed && A[WIDTH-1];
                        div_zero <= (B == '0);
                        dvd_orig <= A;
                        if (md_op[1]) begin
                            mcand_dvs <= abs_b;
                            shreg     <= abs_a;
                        end else begin
                            mcand_dvs <= abs_a;
                            shreg     <= abs_b;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc   <= step_next;
                        shreg <= is_div ? (shreg << 1) : (shreg >> 1);
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_STEP)
                            state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // HI/LO: architectural writes in IDLE, result commit on leaving FIN.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= fin_commit;
            if (fin_commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == S_IDLE) begin
                if (mthi) hi <= A;
                if (mtlo) lo <= A;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    md_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .flush  (flush),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation at cycle 0 and follow it to the done pulse.
    // With inject set, a second start (MULTU 6x7) is driven at cycle 5.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit inject);
        int  cyc;
        int  busy_cnt;
        bit  seen;
        md_op = op;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (inject && cyc == 5) begin
                    start = 1'b1;
                    md_op = OP_MULTU;
                    A     = 32'd6;
                    B     = 32'd7;
                end else begin
                    start = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, seen ? cyc : 0, 64'd34);
        check({tag, "_busy_cycles"}, busy_cnt, 64'd33);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        tick();
        check({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int done_cnt;
        resetn = 1'b0;
        start  = 1'b0;
        md_op  = OP_MULT;
        A      = '0;
        B      = '0;
        flush  = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        do_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op("divu_zero", OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b0);
        do_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        do_op("div_zero",  OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
        do_op("div_mixed", OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        do_op("divu_busy_start", OP_DIVU, 32'd100, 32'd3,        32'h00000001, 32'h00000021, 1'b1);

        // mthi preload, then flush a DIVU mid-flight; mtlo while busy is ignored.
        A    = 32'h11111111;
        mthi = 1'b1;
        tick();
        mthi = 1'b0;
        check("mthi_write", hi, 32'h11111111);
        md_op = OP_DIVU;
        A     = 32'd100;
        B     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            mtlo  = (c == 3);
            A     = (c == 3) ? 32'hDEADBEEF : 32'd100;
            flush = (c == 10);
            tick();
        end
        mtlo  = 1'b0;
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_cnt++;
            tick();
        end
        check("flush_no_done", done_cnt, 0);
        check("flush_hi", hi, 32'h11111111);
        check("flush_lo_mtlo_busy", lo, 32'h00000021);

        // Reset in the middle of a MULT.
        md_op = OP_MULT;
        A     = 32'hFFFFFFFD;
        B     = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        check("pre_reset_busy", busy, 1'b1);
        resetn = 1'b0;
        #2;
        check("midreset_busy", busy, 1'b0);
        check("midreset_hi", hi, 32'h0);
        check("midreset_lo", lo, 32'h0);
        check("midreset_done", done, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("post_reset_done", done, 1'b0);
        do_op("multu_small", OP_MULTU, 32'd6, 32'd7, 32'h00000000, 32'd42, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
